count_ctrl: RTL and testbench
=============================

# count_ctrl

Run/pause/clear sequencer for the 8-bit up-counter and dual hex-digit display datapath. It synchronises and edge-detects two push-button inputs and prescales the system clock into one-cycle count-enable ticks. It drives the counter's enable and active-low clear, and stops counting when the counter reaches a programmable limit. It sits between the board keys and the counter; the counter value is fed back in so the block can detect the terminal count.

## Interface
Parameters:
- DIV, 50_000_000: clock cycles per count tick; DIV ≥ 2.
- LIMIT, 8'hFF: terminal count; counting stops when the counter reaches this value; 1 ≤ LIMIT ≤ 255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- key_go  in  1  run/pause toggle button, asynchronous level, active-high.
- key_zero  in  1  clear-count button, asynchronous level, active-high.
- cnt_q  in  8  current counter value, fed back from the counter.
- cnt_en  out  1  count enable to counter T input; one-cycle tick.
- cnt_clr_n  out  1  active-low clear to counter R input.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.

## Operation
- Input conditioning: each key passes through a 2-FF synchroniser and then a rising-edge detector. This produces go_p and zero_p, each a one-cycle pulse per press. A held key produces exactly one pulse.
- States: ZERO, IDLE, RUN, PAUSE, DONE. State is registered.
- Reset (clr=1 at an edge):
  - state←ZERO, div_cnt←0, all synchroniser and edge flops←0.
- Output decodes (combinational from registered state):
  - cnt_clr_n = 0 only in ZERO.
  - running = RUN; paused = PAUSE; done = DONE.
  - cnt_en = (state==RUN) && (div_cnt==DIV-1).
- Prescaler div_cnt, width ceil(log2 DIV):
  - Increments only in RUN.
  - Wraps DIV-1→0; the wrap cycle is the tick cycle.
  - Holds its value in PAUSE.
  - Forced to 0 in ZERO, IDLE and DONE.
- Transitions, evaluated at each edge in priority order:
  1. zero_p from any state → ZERO.
  2. ZERO → IDLE unconditionally. Low time of cnt_clr_n is exactly one cycle unless zero_p repeats.
  3. IDLE + go_p → RUN if cnt_q < LIMIT, else → DONE.
  4. RUN, tick cycle with cnt_q == LIMIT-1 → DONE. The counter reaches LIMIT on the same edge. This overrides go_p.
  5. RUN + go_p → PAUSE. If go_p coincides with a tick, the tick is still issued and div_cnt wraps to 0.
  6. PAUSE + go_p → RUN, resuming from the held div_cnt.
  7. DONE: go_p ignored; only zero_p leaves.
- zero_p and go_p in the same cycle: zero wins and go_p is discarded.
- No external counter increments occur outside RUN. cnt_en is never high in ZERO, IDLE, PAUSE or DONE.

## Timing
- Reset values:
  - While clr is high: cnt_clr_n=0, cnt_en=0, running=0, paused=0, done=0.
  - First cycle after clr drops: cnt_clr_n=0 (ZERO).
  - Next cycle: cnt_clr_n=1 (IDLE).
- Key latency: key sampled high at edge n → pulse valid in the cycle after edge n+2 → state change at edge n+3.
- Tick spacing in RUN: first cnt_en occurs DIV cycles after entering RUN from IDLE, then every DIV cycles. The counter increments at the edge that ends the cnt_en cycle.
- Pause/resume: total RUN cycles between ticks is always DIV; PAUSE cycles are not counted.
- Reset mid-operation: takes effect at the next edge from any state and overrides all key pulses.
- cnt_q is sampled only in IDLE (on go_p) and on RUN tick cycles. It must be stable at those edges; the counter is same-clock, so this holds.

## Test plan
Bench uses DIV=4, LIMIT=5.
- Reset: hold clr 3 cycles, then release → cnt_clr_n=0 during reset and 1 cycle after, then 1; running=paused=done=0; cnt_en never high.
- Start: key_go high for 10 cycles from IDLE → running at edge n+3 with a single toggle; cnt_en one-cycle pulses at 4, 8, 12 cycles after RUN entry; counter model 0→1→2→3.
- Pause/resume: go pulse 2 cycles after a tick → PAUSE, cnt_en low for 20 cycles; second go → RUN, next cnt_en after 2 more RUN cycles.
- Terminal: run from cnt_q=0 → after tick 5 (cnt_q 4→5) done=1, running=0, no further cnt_en; a go press leaves done=1.
- Clear: key_zero in RUN with cnt_q=3 → one cycle cnt_clr_n=0, then IDLE with cnt_en=0; key_go and key_zero rising the same cycle → ZERO, then IDLE, no RUN.
- Reset mid-run: clr asserted on a tick cycle → the following cycle has cnt_en=0 and cnt_clr_n=0; after release, ZERO then IDLE.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/clear sequencer for an external 8-bit up-counter.
// Conditions two push-buttons, prescales clk into count ticks, and stops
// the counter once the fed-back value reaches LIMIT.
module count_ctrl #(
  parameter int          DIV   = 50_000_000,
  parameter logic [7:0]  LIMIT = 8'hFF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_go,
  input  logic       key_zero,
  input  logic [7:0] cnt_q,
  output logic       cnt_en,
  output logic       cnt_clr_n,
  output logic       running,
  output logic       paused,
  output logic       done
);

  localparam int             DW      = $clog2(DIV);
  localparam logic [DW-1:0]  DIV_MAX = DW'(DIV - 1);
  localparam logic [7:0]     LIM_M1  = LIMIT - 8'd1;

  typedef enum logic [2:0] {S_ZERO, S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  // Key conditioning lanes: bit 0 = go, bit 1 = zero
  logic [1:0] r_sync1, r_sync2, r_dly, r_pulse;
  logic       w_go_p, w_zero_p;

  state_t        r_state, w_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic          w_tick;

  // 2-FF synchroniser followed by a registered rising-edge detector
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_dly   <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= {key_zero, key_go};
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
      r_pulse <= r_sync2 & ~r_dly;
    end
  end

  assign w_go_p   = r_pulse[0];
  assign w_zero_p = r_pulse[1];

  // Tick cycle is the RUN cycle in which the prescaler wraps
  assign w_tick = (r_state == S_RUN) && (r_div == DIV_MAX);

  // State and prescaler registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_ZERO;
      r_div   <= '0;
    end else begin
      r_state <= w_nxt;
      r_div   <= w_div_nxt;
    end
  end

  // Next-state logic; zero press outranks everything, terminal count outranks go
  always_comb begin
    w_nxt = r_state;
    if (w_zero_p) begin
      w_nxt = S_ZERO;
    end else begin
      case (r_state)
        S_ZERO:  w_nxt = S_IDLE;
        S_IDLE:  if (w_go_p) w_nxt = (cnt_q < LIMIT) ? S_RUN : S_DONE;
        S_RUN: begin
          if (w_tick && (cnt_q == LIM_M1)) w_nxt = S_DONE;
          else if (w_go_p)                 w_nxt = S_PAUSE;
        end
        S_PAUSE: if (w_go_p) w_nxt = S_RUN;
        S_DONE:  w_nxt = S_DONE;
        default: w_nxt = S_ZERO;
      endcase
    end
  end

  // Prescaler: counts in RUN, holds in PAUSE, cleared on entry to any other state
  always_comb begin
    w_div_nxt = r_div;
    if (w_nxt == S_ZERO || w_nxt == S_IDLE || w_nxt == S_DONE)
      w_div_nxt = '0;
    else if (r_state == S_RUN)
      w_div_nxt = w_tick ? '0 : r_div + DW'(1);
  end

  // Output decode from registered state
  always_comb begin
    cnt_clr_n = (r_state != S_ZERO);
    running   = (r_state == S_RUN);
    paused    = (r_state == S_PAUSE);
    done      = (r_state == S_DONE);
    cnt_en    = w_tick;
  end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed scoreboard bench for count_ctrl (DIV=4, LIMIT=5).
// Stimulus pushes per-cycle expected flags/counter values; a negedge monitor
// pops and compares them.
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_go, key_zero;
  logic [7:0] cnt_q = 8'd0;
  logic       cnt_en, cnt_clr_n, running, paused, done;

  // expected vector order: {cnt_clr_n, cnt_en, running, paused, done}
  localparam logic [4:0] ZR = 5'b00000;
  localparam logic [4:0] ID = 5'b10000;
  localparam logic [4:0] RN = 5'b10100;
  localparam logic [4:0] TK = 5'b11100;
  localparam logic [4:0] PS = 5'b10010;
  localparam logic [4:0] DN = 5'b10001;

  typedef struct {
    string      nm;
    logic [4:0] f;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  count_ctrl #(.DIV(4), .LIMIT(8'd5)) dut (
    .clk       (clk),
    .clr       (clr),
    .key_go    (key_go),
    .key_zero  (key_zero),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .running   (running),
    .paused    (paused),
    .done      (done)
  );

  always #5 clk = ~clk;

  // External counter: clear when cnt_clr_n low, increment on cnt_en
  always @(posedge clk) begin
    if (cnt_clr_n !== 1'b1) cnt_q <= 8'd0;
    else if (cnt_en)        cnt_q <= cnt_q + 8'd1;
  end

  // Monitor: compare the cycle's outputs against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = sb.pop_front();
      act = {cnt_clr_n, cnt_en, running, paused, done};
      checks++;
      if (act !== e.f || cnt_q !== e.q) begin
        errors++;
        $display("FAIL %s: got flags=%b q=%0d, expected flags=%b q=%0d (t=%0t)",
                 e.nm, act, cnt_q, e.f, e.q, $time);
      end
    end
  end

  task automatic chk(input string nm, input logic [4:0] f, input logic [7:0] q);
    exp_t e;
    @(posedge clk); #1;
    e.nm = nm; e.f = f; e.q = q;
    sb.push_back(e);
  endtask

  task automatic chkn(input string nm, input logic [4:0] f, input logic [7:0] q, input int n);
    for (int i = 0; i < n; i++) chk(nm, f, q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; key_go = 1'b0; key_zero = 1'b0;

    // reset held 3 cycles, released in the third
    chk("rst", ZR, 0); chk("rst", ZR, 0);
    chk("rst_rel_zero", ZR, 0); clr = 1'b0;
    chk("rel_idle", ID, 0); chk("rel_idle", ID, 0);

    // start: key_go held 10 cycles, single toggle
    key_go = 1'b1;
    chkn("go_sync", ID, 0, 3);
    chkn("run", RN, 0, 3);
    chk("tick1", TK, 0);
    chkn("run", RN, 1, 3); key_go = 1'b0;
    chk("tick2", TK, 1);
    chkn("run", RN, 2, 3); key_go = 1'b1;
    chk("tick3", TK, 2);
    chkn("run", RN, 3, 2); key_go = 1'b0;

    // pause 20 cycles, resume press near the end
    chkn("pause", PS, 3, 17); key_go = 1'b1;
    chkn("pause", PS, 3, 2);  key_go = 1'b0;
    chk("pause", PS, 3);
    chk("resume", RN, 3);
    chk("tick4", TK, 3);
    chkn("run", RN, 4, 3);
    chk("tick5", TK, 4);
    chkn("done", DN, 5, 3);

    // go in DONE is ignored
    key_go = 1'b1;
    chkn("done_go", DN, 5, 6); key_go = 1'b0;
    chk("done_go", DN, 5);

    // zero from DONE
    key_zero = 1'b1;
    chkn("zero_sync", DN, 5, 3);
    chk("zero_from_done", ZR, 5);
    chk("zero_idle", ID, 0); key_zero = 1'b0;
    chk("zero_idle", ID, 0);

    // run to cnt_q=3 then zero
    key_go = 1'b1;
    chk("go_sync", ID, 0); chk("go_sync", ID, 0); key_go = 1'b0;
    chk("go_sync", ID, 0);
    chkn("run", RN, 0, 3); chk("tick", TK, 0);
    chkn("run", RN, 1, 3); chk("tick", TK, 1);
    chkn("run", RN, 2, 3); chk("tick", TK, 2);
    key_zero = 1'b1;
    chkn("run_q3", RN, 3, 3);
    chk("zero_in_run", ZR, 3);
    chk("zero_run_idle", ID, 0); key_zero = 1'b0;
    chkn("zero_run_idle", ID, 0, 2);

    // go and zero rising together: zero wins, no RUN
    key_go = 1'b1; key_zero = 1'b1;
    chkn("both_sync", ID, 0, 3);
    chk("both_zero", ZR, 0);
    chk("both_idle", ID, 0); key_go = 1'b0; key_zero = 1'b0;
    chkn("both_idle", ID, 0, 4);

    // reset asserted on a tick cycle
    key_go = 1'b1;
    chk("go_sync", ID, 0); chk("go_sync", ID, 0); key_go = 1'b0;
    chk("go_sync", ID, 0);
    chkn("run", RN, 0, 3);
    chk("tick_rst", TK, 0); clr = 1'b1;
    chk("rst_mid", ZR, 1);
    chk("rst_mid_zero", ZR, 0); clr = 1'b0;
    chkn("rst_mid_idle", ID, 0, 2);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
